// File: rtl/seq_source_pkg.sv
// Shared types and helpers for the ndata sequence source: the config word layout,
// FSM states and the per-beat lane keep mask.
package seq_source_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_ELEMENTS = 8;
    localparam int COUNT_WIDTH  = 32;

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    typedef struct packed {
        data_t  start;
        data_t  step;
        count_t count;
    } cfg_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam count_t BEAT_COUNT = count_t'(NUM_ELEMENTS);

    // Lane i is kept while more than i elements are still owed to the packet.
    function automatic logic [NUM_ELEMENTS-1:0] keep_mask(input count_t remaining);
        logic [NUM_ELEMENTS-1:0] mask;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            mask[i] = (remaining > count_t'(i));
        end
        return mask;
    endfunction

endpackage

// File: rtl/ndata_seq_source.sv
// Arithmetic sequence generator: one packet per accepted config word, packed
// NUM_ELEMENTS per beat with keep/last framing.
import seq_source_pkg::*;

module ndata_seq_source (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  cfg_t                           cfg,
    output data_t [NUM_ELEMENTS-1:0]       out_data,
    output logic  [NUM_ELEMENTS-1:0]       out_keep,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    state_t state;
    data_t  stride;
    count_t remaining;
    count_t rem_next;
    logic   out_fire;
    logic   cfg_fire;

    // A new config may land on the final-beat handshake so packets run back-to-back.
    always_comb begin
        out_fire  = out_valid && out_ready;
        cfg_ready = rst_n && ((state == IDLE) || (out_fire && out_last));
        cfg_fire  = cfg_valid && cfg_ready;
        rem_next  = (remaining > BEAT_COUNT) ? (remaining - BEAT_COUNT) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_keep  <= '0;
        end else if (cfg_fire) begin
            state     <= RUN;
            out_valid <= 1'b1;
            remaining <= cfg.count;
            stride    <= cfg.step * data_t'(NUM_ELEMENTS);
            out_keep  <= keep_mask(cfg.count);
            out_last  <= (cfg.count <= BEAT_COUNT);
        end else if (out_fire) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_keep  <= '0;
            end else begin
                remaining <= rem_next;
                out_keep  <= keep_mask(rem_next);
                out_last  <= (rem_next <= BEAT_COUNT);
            end
        end
    end

    // Each lane steps by the whole-beat stride, wrapping modulo 2^DATA_WIDTH.
    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
        data_t lane;

        always_ff @(posedge clk) begin
            if (cfg_fire) begin
                lane <= cfg.start + cfg.step * data_t'(i);
            end else if (out_fire) begin
                lane <= lane + stride;
            end
        end

        assign out_data[i] = lane;
    end

endmodule

// File: tb/tb_ndata_seq_source.sv
// Directed bench for ndata_seq_source: basic, exact-multiple, empty, wrap,
// back-to-back, backpressure and mid-packet reset cases.
import seq_source_pkg::*;

module tb_ndata_seq_source;

    localparam int VW = DATA_WIDTH * NUM_ELEMENTS;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cfg_valid;
    logic                      cfg_ready;
    cfg_t                      cfg;
    data_t [NUM_ELEMENTS-1:0]  out_data;
    logic  [NUM_ELEMENTS-1:0]  out_keep;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    int vectors    = 0;
    int miscompares = 0;

    ndata_seq_source dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg       (cfg),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input data_t s, input data_t st,
                                 input count_t c, input logic r);
        cfg_valid  = v;
        cfg.start  = s;
        cfg.step   = st;
        cfg.count  = c;
        out_ready  = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input data_t first, input data_t st,
                             input logic [NUM_ELEMENTS-1:0] keep, input logic last);
        data_t e;
        checkOutput({tag, "_valid"}, VW'(out_valid), VW'(1'b1));
        checkOutput({tag, "_keep"}, VW'(out_keep), VW'(keep));
        checkOutput({tag, "_last"}, VW'(out_last), VW'(last));
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            e = first + data_t'(i) * st;
            checkOutput($sformatf("%s_d%0d", tag, i), VW'(out_data[i]), VW'(e));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int lasts;
        logic stalled;
        logic done;
        data_t [NUM_ELEMENTS-1:0] prev_data;
        logic  [NUM_ELEMENTS-1:0] prev_keep;
        logic                     prev_last;

        // Reset: everything quiet, config not accepted.
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        step();
        step();
        checkOutput("rst_valid", VW'(out_valid), VW'(1'b0));
        checkOutput("rst_keep", VW'(out_keep), VW'(0));
        checkOutput("rst_last", VW'(out_last), VW'(1'b0));
        checkOutput("rst_cfg_ready", VW'(cfg_ready), VW'(1'b0));
        rst_n = 1'b1;
        #1;
        checkOutput("idle_cfg_ready", VW'(cfg_ready), VW'(1'b1));

        // Basic packet {0,1,20}: three beats, first one valid right after the handshake.
        applyStimulus(1'b1, 32'd0, 32'd1, 32'd20, 1'b1);
        checkOutput("basic_pre_valid", VW'(out_valid), VW'(1'b0));
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkBeat("basic_b1", 32'd0, 32'd1, 8'hFF, 1'b0);
        checkOutput("basic_b1_cfg_ready", VW'(cfg_ready), VW'(1'b0));
        step();
        checkBeat("basic_b2", 32'd8, 32'd1, 8'hFF, 1'b0);
        step();
        checkBeat("basic_b3", 32'd16, 32'd1, 8'h0F, 1'b1);
        checkOutput("basic_b3_cfg_ready", VW'(cfg_ready), VW'(1'b1));
        step();
        checkOutput("basic_end_valid", VW'(out_valid), VW'(1'b0));

        // Exact multiple {5,2,16}: two full beats, no trailing empty beat.
        applyStimulus(1'b1, 32'd5, 32'd2, 32'd16, 1'b1);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkBeat("mult_b1", 32'd5, 32'd2, 8'hFF, 1'b0);
        step();
        checkBeat("mult_b2", 32'd21, 32'd2, 8'hFF, 1'b1);
        step();
        checkOutput("mult_end_valid", VW'(out_valid), VW'(1'b0));

        // Zero count {9,4,0}: one empty beat carrying the start lanes.
        applyStimulus(1'b1, 32'd9, 32'd4, 32'd0, 1'b1);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkBeat("zero_b1", 32'd9, 32'd4, 8'h00, 1'b1);
        step();
        checkOutput("zero_end_valid", VW'(out_valid), VW'(1'b0));

        // Wrap {FFFFFFFE,1,4}.
        applyStimulus(1'b1, 32'hFFFF_FFFE, 32'd1, 32'd4, 1'b1);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("wrap_d2", VW'(out_data[2]), VW'(32'h0000_0000));
        checkBeat("wrap_b1", 32'hFFFF_FFFE, 32'd1, 8'h0F, 1'b1);
        step();

        // Back-to-back: {0,1,10} then {200,10,3} held valid during the first packet.
        applyStimulus(1'b1, 32'd0, 32'd1, 32'd10, 1'b1);
        step();
        applyStimulus(1'b1, 32'd200, 32'd10, 32'd3, 1'b1);
        checkBeat("b2b_p1b1", 32'd0, 32'd1, 8'hFF, 1'b0);
        checkOutput("b2b_p1b1_cfg_ready", VW'(cfg_ready), VW'(1'b0));
        step();
        checkBeat("b2b_p1b2", 32'd8, 32'd1, 8'h03, 1'b1);
        checkOutput("b2b_p1b2_cfg_ready", VW'(cfg_ready), VW'(1'b1));
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkBeat("b2b_p2b1", 32'd200, 32'd10, 8'h07, 1'b1);
        step();
        checkOutput("b2b_end_valid", VW'(out_valid), VW'(1'b0));

        // Backpressure {0,3,50} with random ready: fields hold across stalls.
        applyStimulus(1'b1, 32'd0, 32'd3, 32'd50, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        k = 0;
        lasts = 0;
        stalled = 1'b0;
        done = 1'b0;
        prev_data = '0;
        prev_keep = '0;
        prev_last = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("bp_valid", VW'(out_valid), VW'(1'b1));
            if (stalled) begin
                checkOutput("bp_hold_data", VW'(out_data), VW'(prev_data));
                checkOutput("bp_hold_keep", VW'(out_keep), VW'(prev_keep));
                checkOutput("bp_hold_last", VW'(out_last), VW'(prev_last));
            end
            if (out_ready) begin
                for (int i = 0; i < NUM_ELEMENTS; i++) begin
                    if (out_keep[i]) begin
                        checkOutput("bp_data", VW'(out_data[i]), VW'(data_t'(3 * k)));
                        k++;
                    end
                end
                if (out_last) begin
                    lasts++;
                    done = 1'b1;
                end
            end
            stalled   = !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
            step();
        end
        checkOutput("bp_done", VW'(done), VW'(1'b1));
        checkOutput("bp_elements", VW'(k), VW'(50));
        checkOutput("bp_lasts", VW'(lasts), VW'(1));
        checkOutput("bp_end_valid", VW'(out_valid), VW'(1'b0));

        // Reset during beat 2 of a count=40 packet, then a fresh packet.
        applyStimulus(1'b1, 32'd0, 32'd1, 32'd40, 1'b1);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        step();
        checkBeat("mid_b2", 32'd8, 32'd1, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cfg_ready", VW'(cfg_ready), VW'(1'b0));
        step();
        checkOutput("mid_rst_valid1", VW'(out_valid), VW'(1'b0));
        checkOutput("mid_rst_cfg_ready1", VW'(cfg_ready), VW'(1'b0));
        step();
        checkOutput("mid_rst_valid2", VW'(out_valid), VW'(1'b0));
        checkOutput("mid_rst_last2", VW'(out_last), VW'(1'b0));
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'd100, 32'd1, 32'd8, 1'b1);
        checkOutput("post_rst_cfg_ready", VW'(cfg_ready), VW'(1'b1));
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkBeat("post_rst_b1", 32'd100, 32'd1, 8'hFF, 1'b1);
        step();
        checkOutput("post_rst_end_valid", VW'(out_valid), VW'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
